// File: rtl/mem_dispatch_ctrl.sv
// Core/VGA memory dispatch: RAM, memory-mapped IO channels and a status word.
// Optional unmapped-access sticky error logic is built under `define MEMCTRL_ERR_EN.
module mem_dispatch_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 24,
  parameter int                RAM_AW   = 15,
  parameter int                NUM_IO   = 4,
  parameter logic [ADDR_W-1:0] IO_BASE  = 24'hFFFF00,
  parameter logic [7:0]        STAT_OFS = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [ADDR_W-1:0]        core_addr,
  input  logic [DATA_W-1:0]        core_wdata,
  output logic [DATA_W-1:0]        core_rdata,
  output logic                     core_rvalid,
  input  logic [RAM_AW-1:0]        vga_addr,
  output logic [DATA_W-1:0]        vga_rdata,
  input  logic [NUM_IO*DATA_W-1:0] io_data,
  input  logic [NUM_IO-1:0]        io_valid,
  output logic [NUM_IO-1:0]        io_been_read,
  output logic                     err_flag
);

  localparam int                DEPTH     = 1 << RAM_AW;
  localparam logic [ADDR_W-1:0] STAT_ADDR = IO_BASE + ADDR_W'(STAT_OFS);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_vga;
  logic [NUM_IO-1:0] r_been;
  logic [NUM_IO-1:0] r_new;

  logic              w_rd;
  logic              w_wr;
  logic              w_is_ram;
  logic              w_is_io;
  logic              w_is_stat;
  logic              w_unmap;
  logic [NUM_IO-1:0] w_io_hit;
  logic [NUM_IO-1:0] w_io_rd;
  logic [RAM_AW-1:0] w_ram_a;
  logic [DATA_W-1:0] w_io_mux;
  logic [DATA_W-1:0] w_stat;
  logic [DATA_W-1:0] w_rd_mux;
  logic              w_err;

  assign w_rd    = core_req & ~core_we;
  assign w_wr    = core_req &  core_we;
  assign w_ram_a = core_addr[RAM_AW-1:0];

  // RAM only when every bit above the RAM index is zero; no aliasing.
  assign w_is_ram  = (core_addr[ADDR_W-1:RAM_AW] == '0);
  assign w_is_stat = (core_addr == STAT_ADDR);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_io
      localparam logic [ADDR_W-1:0] CH_ADDR = IO_BASE + ADDR_W'(gi);
      assign w_io_hit[gi] = (core_addr == CH_ADDR);
    end
  endgenerate

  assign w_is_io = |w_io_hit;
  assign w_unmap = ~(w_is_ram | w_is_io | w_is_stat);
  assign w_io_rd = {NUM_IO{w_rd}} & w_io_hit;

  always_comb begin
    w_io_mux = '0;
    for (int i = 0; i < NUM_IO; i++)
      if (w_io_hit[i]) w_io_mux = io_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    w_stat             = '0;
    w_stat[NUM_IO-1:0] = r_new;
    w_stat[DATA_W-1]   = w_err;
  end

  always_comb begin
    w_rd_mux = '0;
    if (!w_unmap) begin
      if (w_is_ram)      w_rd_mux = r_mem[w_ram_a];
      else if (w_is_io)  w_rd_mux = w_io_mux;
      else if (w_is_stat) w_rd_mux = w_stat;
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr && w_is_ram) r_mem[w_ram_a] <= core_wdata;
  end

  // Non-blocking read of r_mem gives read-first behaviour against a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_vga    <= '0;
      r_been   <= '0;
      r_new    <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rd_mux;
      r_vga  <= r_mem[vga_addr];
      r_been <= w_io_rd;
      // A new sample in the same cycle as the clearing read keeps the flag set.
      r_new  <= io_valid | (r_new & ~w_io_rd);
    end
  end

`ifdef MEMCTRL_ERR_EN
  logic r_err;
  logic w_stat_rd;
  assign w_stat_rd = w_rd & w_is_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= (core_req & w_unmap) | (r_err & ~w_stat_rd);
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  assign core_rdata   = r_rdata;
  assign core_rvalid  = r_rvalid;
  assign vga_rdata    = r_vga;
  assign io_been_read = r_been;
  assign err_flag     = w_err;

endmodule

// File: tb/tb_mem_dispatch_ctrl.sv
// Directed bench for mem_dispatch_ctrl; read expectations go through a scoreboard queue.
module tb_mem_dispatch_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;
  localparam int RAM_AW = 15;
  localparam int NUM_IO = 4;
  localparam logic [ADDR_W-1:0] IO_BASE   = 24'hFFFF00;
  localparam logic [ADDR_W-1:0] STAT_ADDR = 24'hFFFFFF;
`ifdef MEMCTRL_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     core_req;
  logic                     core_we;
  logic [ADDR_W-1:0]        core_addr;
  logic [DATA_W-1:0]        core_wdata;
  logic [DATA_W-1:0]        core_rdata;
  logic                     core_rvalid;
  logic [RAM_AW-1:0]        vga_addr;
  logic [DATA_W-1:0]        vga_rdata;
  logic [NUM_IO*DATA_W-1:0] io_data;
  logic [NUM_IO-1:0]        io_valid;
  logic [NUM_IO-1:0]        io_been_read;
  logic                     err_flag;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_dispatch_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW), .NUM_IO(NUM_IO),
    .IO_BASE(IO_BASE), .STAT_OFS(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .vga_addr(vga_addr), .vga_rdata(vga_rdata),
    .io_data(io_data), .io_valid(io_valid), .io_been_read(io_been_read),
    .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    core_req = 1'b0;
    tick();
    io_valid = '0;
    chk({tag, "_rvalid0"}, 32'(core_rvalid), 32'd0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
    tick();
    core_req = 1'b0; core_we = 1'b0; io_valid = '0;
    chk("wr_no_rvalid", 32'(core_rvalid), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    logic [DATA_W-1:0] want;
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    exp_q.push_back(e);
    tick();
    core_req = 1'b0; io_valid = '0;
    want = exp_q.pop_front();
    chk({tag, "_rvalid"}, 32'(core_rvalid), 32'd1);
    chk({tag, "_rdata"}, 32'(core_rdata), 32'(want));
  endtask

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    vga_addr = '0; io_data = '0; io_valid = '0;
    #2;
    chk("rst_rdata", 32'(core_rdata), 32'd0);
    chk("rst_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst_vga", 32'(vga_rdata), 32'd0);
    chk("rst_been", 32'(io_been_read), 32'd0);
    chk("rst_err", 32'(err_flag), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // RAW through RAM and back-to-back reads
    wr(24'h001234, 16'hBEEF);
    rd("raw", 24'h001234, 16'hBEEF);
    idle("after_raw");
    chk("rdata_hold", 32'(core_rdata), 32'h0000BEEF);
    wr(24'h007FFF, 16'h7E7E);
    rd("top_word", 24'h007FFF, 16'h7E7E);
    rd("b2b", 24'h001234, 16'hBEEF);

    // VGA read-first collision
    wr(24'h000010, 16'h5555);
    vga_addr = 15'h0010;
    wr(24'h000010, 16'hAAAA);
    chk("vga_old", 32'(vga_rdata), 32'h00005555);
    idle("vga");
    chk("vga_new", 32'(vga_rdata), 32'h0000AAAA);

    // New-data flag and been-read pulse
    io_data[2*DATA_W +: DATA_W] = 16'h0042;
    io_valid = 4'b0100;
    idle("ioval");
    rd("stat_new2", STAT_ADDR, 16'h0004);
    rd("io2", IO_BASE + 24'd2, 16'h0042);
    chk("been2", 32'(io_been_read), 32'h4);
    rd("stat_clr", STAT_ADDR, 16'h0000);
    chk("been_off", 32'(io_been_read), 32'h0);

    // Set wins over clear
    io_data[1*DATA_W +: DATA_W] = 16'h1111;
    io_valid = 4'b0010;
    rd("io1_setwin", IO_BASE + 24'd1, 16'h1111);
    chk("been1", 32'(io_been_read), 32'h2);
    rd("stat_keep1", STAT_ADDR, 16'h0002);
    rd("io1_clr", IO_BASE + 24'd1, 16'h1111);
    rd("stat_zero", STAT_ADDR, 16'h0000);

    // Dropped IO write, unmapped accesses and the error sticky bit
    wr(IO_BASE, 16'hFFFF);
    rd("stat_iowr", STAT_ADDR, 16'h0000);
    rd("unmap", 24'h800000, 16'h0000);
    chk("err_set", 32'(err_flag), 32'(ERR));
    rd("stat_err", STAT_ADDR, ERR ? 16'h8000 : 16'h0000);
    chk("err_clr", 32'(err_flag), 32'd0);
    wr(24'h000000, 16'h1234);
    rd("no_alias", 24'h008000, 16'h0000);
    rd("ram0", 24'h000000, 16'h1234);
    wr(24'hABCDEF, 16'h0001);
    chk("err_wr", 32'(err_flag), 32'(ERR));
    rd("stat_err2", STAT_ADDR, ERR ? 16'h8000 : 16'h0000);

    // Reset while a read response is pending
    io_valid = 4'b1000;
    core_req = 1'b1; core_we = 1'b0; core_addr = 24'h001234;
    tick();
    core_req = 1'b0; io_valid = '0;
    chk("pre_rst_rvalid", 32'(core_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rvalid", 32'(core_rvalid), 32'd0);
    chk("async_rdata", 32'(core_rdata), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd("post_rst_stat", STAT_ADDR, 16'h0000);
    rd("post_rst_ram", 24'h001234, 16'hBEEF);
    rd("post_rst_ram2", 24'h000010, 16'hAAAA);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_dispatch_ctrl.md
Name: mem_dispatch_ctrl

Overview:
- Parametrised memory/IO dispatch controller; the next generation of the core-side memory controller.
- Decodes each core access to one of three targets: an inferred dual-port frame/data RAM, NUM_IO memory-mapped input channels (accelerometer, encoders, etc.), or a status register.
- Provides a read-only VGA port on RAM port B.
- Adds over the previous controller: registered fixed-latency read data with a valid strobe, per-channel sticky new-data flags, and per-channel been-read pulses.

Parameters:
- DATA_W, 16, data width of the core, RAM, IO and VGA paths.
- ADDR_W, 24, core address width.
- RAM_AW, 15, RAM address width; depth is 2^RAM_AW words.
- NUM_IO, 4, number of IO input channels (1..15).
- IO_BASE, 24'hFFFF00, core address of channel 0; channel i is at IO_BASE+i.
- STAT_OFS, 8'hFF, status register address is IO_BASE+STAT_OFS; must be >= NUM_IO.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  access request, sampled each cycle.
- core_we  in  1  1 = write, 0 = read; qualified by core_req.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  write data.
- core_rdata  out  DATA_W  registered read data.
- core_rvalid  out  1  one-cycle strobe marking core_rdata valid.
- vga_addr  in  RAM_AW  VGA read address.
- vga_rdata  out  DATA_W  RAM port B data, 1-cycle latency.
- io_data  in  NUM_IO*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- io_valid  in  NUM_IO  per-channel new-sample strobe.
- io_been_read  out  NUM_IO  one-cycle pulse when a channel is read.
- err_flag  out  1  sticky unmapped-access flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): core_rdata=0, core_rvalid=0, vga_rdata=0, io_been_read=0, new_flag=0, err_flag=0. RAM contents are not reset.
- Decode, one access per cycle when core_req=1:
  - RAM: core_addr < 2^RAM_AW.
  - IOi: core_addr == IO_BASE+i, for i < NUM_IO.
  - STAT: core_addr == IO_BASE+STAT_OFS.
  - Anything else is UNMAPPED.
- Read latency: a request in cycle N gives core_rdata valid with core_rvalid=1 in cycle N+1 for every target. core_rvalid is 0 in any cycle not following a read request.
- core_rdata holds its last value between reads.
- RAM write: the word is stored at the clk edge ending cycle N. No core_rvalid is generated for writes.
- Writes to IO or STAT are dropped with no side effects.
- UNMAPPED read returns 0 with core_rvalid=1. UNMAPPED read or write sets the error sticky bit.
- IO read of channel i:
  - Returns io_data[i] as sampled in cycle N.
  - Clears new_flag[i].
  - Pulses io_been_read[i] in cycle N+1.
- new_flag[i] is set by io_valid[i]=1. If the set and the clear happen in the same cycle, set wins: the flag stays 1, the read data is still returned and io_been_read still pulses.
- STAT read returns:
  - bits [NUM_IO-1:0] = new_flag.
  - bit [DATA_W-1] = error sticky bit (0 when the feature is off).
  - all other bits 0.
  - Reading STAT does not clear new_flag.
- VGA port: vga_rdata in cycle N+1 holds RAM[vga_addr] from cycle N. It is independent of the core port.
- Core write and VGA read to the same address in the same cycle: VGA gets the old data (read-first).
- Core write followed by a core read of the same address in the next cycle returns the new data.
- Address wrap: RAM uses only core_addr[RAM_AW-1:0] after decode. Upper bits must be 0 to hit RAM.
- Reset mid-operation: a pending core_rvalid or io_been_read is squashed to 0. A write in the reset cycle is not guaranteed.

Optional Feature:
- Macro: MEMCTRL_ERR_EN.
- Defined:
  - Error sticky bit is set on any UNMAPPED access.
  - err_flag mirrors the bit, which also appears in STAT bit DATA_W-1.
  - The bit is cleared by a STAT read. If a new UNMAPPED access occurs in the same cycle as the STAT read, set wins.
- Undefined:
  - No error logic is built.
  - err_flag is tied 0 and STAT bit DATA_W-1 reads 0.
  - UNMAPPED reads still return 0 with core_rvalid.

Test Plan:
- Write 16'hBEEF to 15'h1234, then read 15'h1234 in the next cycle -> core_rdata=16'hBEEF with core_rvalid=1 exactly one cycle after the read request.
- Write 16'hAAAA to 0x0010 while vga_addr=0x0010 in the same cycle (old word 16'h5555) -> vga_rdata=16'h5555, then 16'hAAAA on the following cycle.
- Pulse io_valid[2] with io_data ch2=16'h0042, then read STAT (IO_BASE+0xFF) -> 16'h0004. Then read IO_BASE+2 -> 16'h0042 and io_been_read=4'b0100 for one cycle. Read STAT again -> 16'h0000.
- Assert io_valid[1] in the same cycle as a read of IO_BASE+1 -> data is returned, io_been_read[1] pulses, and the next STAT read returns 16'h0002.
- With MEMCTRL_ERR_EN: read 24'h800000 -> core_rdata=0 and err_flag=1. STAT read -> 16'h8000, then err_flag=0. Without the macro: err_flag stays 0 and STAT reads 16'h0000.
- Assert rst_n=0 during the cycle after a read request -> core_rvalid=0 and core_rdata=0 immediately (asynchronously). RAM contents are preserved, verified by reading back after reset.
